// File: rtl/tdc_sequencer_if.sv
// Result/sample bus between the TDC sequencer and its consumer.
//
// Handshake: result_valid rises with a new result and stays high, with
// result stable, until a cycle where result_valid and result_ready are both
// high; that cycle is the single transfer. result_ready may be driven
// independently of result_valid. sample/sample_valid is a one-cycle
// broadcast and has no back-pressure.
interface tdc_sequencer_if #(
    parameter int CW = 8
);
    logic [CW-1:0] sample;
    logic          sample_valid;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ready;

    modport master (
        output sample,
        output sample_valid,
        output result,
        output result_valid,
        input  result_ready
    );

    modport slave (
        input  sample,
        input  sample_valid,
        input  result,
        input  result_valid,
        output result_ready
    );
endinterface

// File: rtl/tdc_sequencer.sv
// Conversion sequencer for the counter-based TDC front end. Holds the analog
// reset for SETTLE cycles, then counts until the comparator rises (or the
// counter saturates), and averages 2^AVG_LOG2 such samples into one result.
module tdc_sequencer #(
    parameter int CW       = 8,
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             cont,
    input  logic             trigger,
    output logic             reset,
    output logic             busy,
    output logic             timeout_err,
    output logic [1:0]       state_dbg,
    tdc_sequencer_if.master  res_if
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int AW = CW + AVG_LOG2;
    localparam int IW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] meas_cnt;
    logic [IW-1:0] idx;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic          trig_q;
    logic          edge_det;
    logic          term_cnt;
    logic          timeout_hit;
    logic          capture;
    logic          clear_run;

    // A rising edge needs trigger low in the previous cycle, whatever the state,
    // so a comparator already high on MEAS entry does not count.
    assign edge_det    = trigger & ~trig_q;
    assign term_cnt    = (meas_cnt == CNT_MAX);
    assign timeout_hit = term_cnt & ~edge_det;
    // On timeout the counter already sits at CNT_MAX, so the captured value is
    // meas_cnt in both the edge and the saturated case.
    assign acc_sum     = acc + AW'(meas_cnt);

    assign reset               = (state != MEAS);
    assign busy                = (state != IDLE);
    assign res_if.result_valid = (state == DONE);
    assign state_dbg           = state;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus capture / run-clear strobes for the datapath.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        clear_run = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RST;
                    clear_run = 1'b1;
                end
            end
            RST: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = MEAS;
                end
            end
            MEAS: begin
                if (edge_det || term_cnt) begin
                    capture   = 1'b1;
                    state_nxt = (idx == IDX_LAST) ? DONE : RST;
                end
            end
            DONE: begin
                // result_valid is high throughout DONE, so ready alone completes the transfer.
                if (res_if.result_ready) begin
                    clear_run = cont;
                    state_nxt = cont ? RST : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, sample capture, accumulation and result load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            trig_q              <= 1'b0;
            settle_cnt          <= '0;
            meas_cnt            <= '0;
            idx                 <= '0;
            acc                 <= '0;
            timeout_err         <= 1'b0;
            res_if.sample       <= '0;
            res_if.sample_valid <= 1'b0;
            res_if.result       <= '0;
        end else begin
            trig_q              <= trigger;
            res_if.sample_valid <= capture;

            if (state == RST) begin
                settle_cnt <= settle_cnt + SW'(1);
            end else begin
                settle_cnt <= '0;
            end

            if (state == MEAS) begin
                meas_cnt <= meas_cnt + CW'(1);
            end else begin
                meas_cnt <= '0;
            end

            if (clear_run) begin
                acc         <= '0;
                idx         <= '0;
                timeout_err <= 1'b0;
            end else if (capture) begin
                res_if.sample <= meas_cnt;
                acc           <= acc_sum;
                if (timeout_hit) begin
                    timeout_err <= 1'b1;
                end
                if (idx == IDX_LAST) begin
                    res_if.result <= acc_sum[AW-1:AVG_LOG2];
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdc_sequencer.sv
// Bench for tdc_sequencer: cycle-accurate expectations derived from the
// conversion timing rules, with a queue of expected samples and a running
// sum that yields the expected averaged result.
module tb_tdc_sequencer;

    localparam int CW       = 8;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
    localparam int NS       = 1 << AVG_LOG2;
    localparam logic [CW-1:0] MAXC = '1;

    logic       clk     = 1'b0;
    logic       n_rst   = 1'b0;
    logic       start   = 1'b0;
    logic       cont    = 1'b0;
    logic       trigger = 1'b0;
    logic       reset;
    logic       busy;
    logic       timeout_err;
    logic [1:0] state_dbg;

    tdc_sequencer_if #(.CW(CW)) rif ();

    tdc_sequencer #(
        .CW       (CW),
        .SETTLE   (SETTLE),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .cont        (cont),
        .trigger     (trigger),
        .reset       (reset),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg),
        .res_if      (rif)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] exp_q[$];
    int            run_sum  = 0;
    bit            run_terr = 1'b0;
    bit            noise_start = 1'b0;
    int            ks[NS];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_noise();
        start = noise_start && ($urandom_range(0, 2) == 0);
        cont  = 1'($urandom_range(0, 1));
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first RST cycle.
    task automatic issue_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || reset !== 1'b1 || timeout_err !== 1'b0 || rif.result_valid !== 1'b0) begin
            bad++;
            $display("FAIL start_entry busy=%b reset=%b terr=%b rv=%b expected 1 1 0 0",
                     busy, reset, timeout_err, rif.result_valid);
        end
        run_sum  = 0;
        run_terr = 1'b0;
    endtask

    // One conversion: k = count at which trigger rises, k < 0 = no edge (timeout).
    // hold keeps trigger high throughout a timeout conversion.
    task automatic one_conv(input int k, input bit hold);
        logic [CW-1:0] want;
        logic [CW-1:0] exp_s;
        int            last_c;
        logic          base;
        want   = (k < 0) ? MAXC : CW'(k);
        last_c = (k < 0) ? ((1 << CW) - 1) : k;
        base   = (k < 0) ? hold : 1'b0;
        exp_q.push_back(want);
        run_sum += int'(want);
        if (k < 0) run_terr = 1'b1;
        for (int i = 0; i < SETTLE; i++) begin
            total++;
            if (reset !== 1'b1 || busy !== 1'b1 || (i > 0 && rif.sample_valid !== 1'b0)) begin
                bad++;
                $display("FAIL settle_phase cyc=%0d reset=%b busy=%b sample_valid=%b expected reset=1 busy=1 sv=0",
                         i, reset, busy, rif.sample_valid);
            end
            trigger = base;
            drive_noise();
            tick();
        end
        for (int c = 0; c <= last_c; c++) begin
            total++;
            if (reset !== 1'b0 || busy !== 1'b1 || rif.sample_valid !== 1'b0 || rif.result_valid !== 1'b0) begin
                bad++;
                $display("FAIL meas_phase count=%0d reset=%b busy=%b sv=%b rv=%b expected 0 1 0 0",
                         c, reset, busy, rif.sample_valid, rif.result_valid);
            end
            trigger = (k == c) ? 1'b1 : base;
            drive_noise();
            tick();
        end
        trigger = 1'b0;
        start   = 1'b0;
        exp_s   = exp_q.pop_front();
        total++;
        if (rif.sample_valid !== 1'b1) begin
            bad++;
            $display("FAIL sample_valid got=%b expected=1", rif.sample_valid);
        end
        total++;
        if (rif.sample !== exp_s) begin
            bad++;
            $display("FAIL sample got=%0d expected=%0d", rif.sample, exp_s);
        end
        total++;
        if (reset !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL post_capture reset=%b busy=%b expected 1 1", reset, busy);
        end
    endtask

    task automatic run_result(input bit hold);
        for (int i = 0; i < NS; i++) begin
            one_conv(ks[i], hold);
        end
    endtask

    // Called at the negedge of the first DONE cycle.
    task automatic finish_result(input int stall, input bit cont_v);
        logic [CW-1:0] exp_res;
        exp_res = CW'(run_sum >> AVG_LOG2);
        total++;
        if (rif.result_valid !== 1'b1 || rif.result !== exp_res) begin
            bad++;
            $display("FAIL result rv=%b got=%0d expected rv=1 result=%0d", rif.result_valid, rif.result, exp_res);
        end
        total++;
        if (timeout_err !== run_terr) begin
            bad++;
            $display("FAIL timeout_err got=%b expected=%b", timeout_err, run_terr);
        end
        for (int d = 0; d < stall; d++) begin
            rif.result_ready = 1'b0;
            drive_noise();
            tick();
            total++;
            if (rif.result_valid !== 1'b1 || rif.result !== exp_res || reset !== 1'b1 ||
                busy !== 1'b1 || rif.sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d rv=%b result=%0d reset=%b busy=%b sv=%b expected 1 %0d 1 1 0",
                         d, rif.result_valid, rif.result, reset, busy, rif.sample_valid, exp_res);
            end
        end
        rif.result_ready = 1'b1;
        cont  = cont_v;
        start = noise_start;
        tick();
        rif.result_ready = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        total++;
        if (rif.result_valid !== 1'b0 || busy !== cont_v || reset !== 1'b1) begin
            bad++;
            $display("FAIL after_handshake rv=%b busy=%b reset=%b expected 0 %b 1",
                     rif.result_valid, busy, reset, cont_v);
        end
        total++;
        if (timeout_err !== (cont_v ? 1'b0 : run_terr)) begin
            bad++;
            $display("FAIL terr_after_handshake got=%b expected=%b", timeout_err, cont_v ? 1'b0 : run_terr);
        end
        if (cont_v) begin
            run_sum  = 0;
            run_terr = 1'b0;
        end
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            total++;
            if (busy !== 1'b0 || reset !== 1'b1 || rif.result_valid !== 1'b0 || rif.sample_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle cyc=%0d busy=%b reset=%b rv=%b sv=%b expected 0 1 0 0",
                         i, busy, reset, rif.result_valid, rif.sample_valid);
            end
            tick();
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (reset !== 1'b1 || busy !== 1'b0 || rif.sample_valid !== 1'b0 || rif.result_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s_ctrl reset=%b busy=%b sv=%b rv=%b expected 1 0 0 0",
                     tag, reset, busy, rif.sample_valid, rif.result_valid);
        end
        total++;
        if (rif.sample !== '0 || rif.result !== '0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL %s_data sample=%0d result=%0d terr=%b expected 0 0 0",
                     tag, rif.sample, rif.result, timeout_err);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        rif.result_ready = 1'b0;
        tick();
        tick();
        check_reset_values("reset");
        n_rst = 1'b1;
        tick();
        check_idle(2);
    endtask

    task automatic test_basic();
        issue_start();
        ks = '{9, 9, 9, 9};
        run_result(1'b0);
        finish_result(3, 1'b0);
        check_idle(3);
    endtask

    task automatic test_average();
        issue_start();
        ks = '{10, 11, 12, 13};
        run_result(1'b0);
        finish_result(0, 1'b0);
        check_idle(1);
    endtask

    task automatic test_timeout();
        issue_start();
        ks = '{-1, 20, 30, 40};
        run_result(1'b0);
        finish_result(2, 1'b0);
        check_idle(2);
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL terr_sticky_idle got=%b expected=1", timeout_err);
        end
        // Edge on the terminal count wins; edge on the very first MEAS cycle.
        issue_start();
        ks = '{0, 255, 1, 254};
        run_result(1'b0);
        finish_result(1, 1'b0);
        check_idle(1);
    endtask

    task automatic test_trigger_high();
        issue_start();
        ks = '{-1, 3, -1, 4};
        run_result(1'b1);
        finish_result(0, 1'b0);
        check_idle(1);
    endtask

    task automatic test_back_pressure();
        issue_start();
        ks = '{5, 6, 7, 8};
        run_result(1'b0);
        finish_result(20, 1'b1);
        ks = '{40, 41, 42, 43};
        run_result(1'b0);
        finish_result(0, 1'b0);
        check_idle(2);
    endtask

    task automatic test_mid_reset();
        issue_start();
        for (int i = 0; i < SETTLE; i++) tick();
        for (int c = 0; c < 50; c++) tick();
        total++;
        if (reset !== 1'b0) begin
            bad++;
            $display("FAIL pre_async_reset reset=%b expected=0", reset);
        end
        #1 n_rst = 1'b0;
        #1;
        check_reset_values("async_meas");
        tick();
        n_rst = 1'b1;
        tick();
        check_idle(2);
        issue_start();
        ks = '{50, 7, 8, 9};
        run_result(1'b0);
        finish_result(1, 1'b0);
        check_idle(1);
    endtask

    task automatic test_reset_in_done();
        issue_start();
        ks = '{1, 2, 3, 4};
        run_result(1'b0);
        total++;
        if (rif.result_valid !== 1'b1) begin
            bad++;
            $display("FAIL done_before_reset rv=%b expected=1", rif.result_valid);
        end
        #1 n_rst = 1'b0;
        #1;
        check_reset_values("async_done");
        tick();
        n_rst = 1'b1;
        tick();
        check_idle(3);
    endtask

    task automatic test_start_ignored();
        noise_start = 1'b1;
        issue_start();
        ks = '{15, 25, 35, 45};
        run_result(1'b0);
        finish_result(5, 1'b0);
        noise_start = 1'b0;
        check_idle(8);
    endtask

    task automatic test_random();
        issue_start();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NS; i++) begin
                ks[i] = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 90));
            end
            run_result(1'($urandom_range(0, 1)));
            finish_result(int'($urandom_range(0, 6)), r < 3);
        end
        check_idle(2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_average();
        test_timeout();
        test_trigger_high();
        test_back_pressure();
        test_mid_reset();
        test_reset_in_done();
        test_start_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
